// File: rtl/rx_unit_if.sv
// Signal bundle between the serial receiver and its surroundings.
// The err_cnt signal exists only when RX_ERR_CNT_EN is defined.
interface rx_unit_if;
    logic       serial_in;
    logic       parity_sel;
    logic       rd_en;
    logic [7:0] data_out;
    logic       parity_err;
    logic       empty;
    logic       full;
    logic       Rx_ready;
    logic       frame_err;
    logic       overrun;
`ifdef RX_ERR_CNT_EN
    logic [7:0] err_cnt;

    modport slave (
        input  serial_in, parity_sel, rd_en,
        output data_out, parity_err, empty, full, Rx_ready, frame_err, overrun, err_cnt
    );
    modport master (
        output serial_in, parity_sel, rd_en,
        input  data_out, parity_err, empty, full, Rx_ready, frame_err, overrun, err_cnt
    );
`else
    modport slave (
        input  serial_in, parity_sel, rd_en,
        output data_out, parity_err, empty, full, Rx_ready, frame_err, overrun
    );
    modport master (
        output serial_in, parity_sel, rd_en,
        input  data_out, parity_err, empty, full, Rx_ready, frame_err, overrun
    );
`endif
endinterface

// File: rtl/rx_unit.sv
// Serial frame receiver: deserialises start/8 data/parity/stop frames into a word FIFO.
// Optional saturating error counter on bus.err_cnt when RX_ERR_CNT_EN is defined.
module rx_unit #(
    parameter int unsigned FIFO_WIDTH_R = 9,
    parameter int unsigned FIFO_DEPTH_R = 16
) (
    input  logic      baud_clk,
    input  logic      rst,
    rx_unit_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH_R);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                    r_state;
    state_e                    w_state_next;
    logic [2:0]                r_bit_cnt;
    logic [7:0]                r_shift;
    logic                      r_par_sel;
    logic                      r_par_bit;

    logic [FIFO_WIDTH_R-1:0]   r_mem [FIFO_DEPTH_R];
    logic [PtrW-1:0]           r_wr_ptr;
    logic [PtrW-1:0]           r_rd_ptr;
    logic [CntW-1:0]           r_count;
    logic [FIFO_WIDTH_R-1:0]   r_rd_word;
    logic                      r_frame_err;
    logic                      r_overrun;

    logic                      w_perr;
    logic [FIFO_WIDTH_R-1:0]   w_wr_word;
    logic                      w_stop_edge;
    logic                      w_wr_req;
    logic                      w_wr;
    logic                      w_rd;
    logic                      w_drop;
    logic                      w_empty;
    logic                      w_full;

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (!bus.serial_in) w_state_next = StData;
            StData:   if (r_bit_cnt == 3'd7) w_state_next = StParity;
            StParity: w_state_next = StStop;
            StStop:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Parity mode is captured at the start bit so a mid-frame change is ignored.
    always_ff @(posedge baud_clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_sel <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!bus.serial_in) begin
                        r_bit_cnt <= '0;
                        r_par_sel <= bus.parity_sel;
                    end
                end
                StData: begin
                    r_shift[r_bit_cnt] <= bus.serial_in;
                    r_bit_cnt          <= r_bit_cnt + 3'd1;
                end
                StParity: r_par_bit <= bus.serial_in;
                default: ;
            endcase
        end
    end

    assign w_perr      = r_par_sel ? ~^{r_shift, r_par_bit} : ^{r_shift, r_par_bit};
    assign w_wr_word   = {w_perr, r_shift};
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CntW'(FIFO_DEPTH_R));
    assign w_stop_edge = (r_state == StStop);
    assign w_wr_req    = w_stop_edge && bus.serial_in;
    assign w_rd        = bus.rd_en && !w_empty;
    // A full FIFO still accepts the frame when a read frees a slot on the same edge.
    assign w_wr        = w_wr_req && (!w_full || w_rd);
    assign w_drop      = w_wr_req && w_full && !w_rd;

    always_ff @(posedge baud_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_wr_word;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_word   <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_edge && !bus.serial_in;
            r_overrun   <= w_drop;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_word <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.data_out   = r_rd_word[7:0];
    assign bus.parity_err = r_rd_word[8];
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.Rx_ready   = (r_count <= CntW'(FIFO_DEPTH_R - 2));
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;

`ifdef RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    logic [8:0] w_err_sum;

    assign w_err_sum = {1'b0, r_err_cnt} + 9'(r_frame_err) + 9'(r_overrun);

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else begin
            r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign bus.err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_rx_unit.sv
// Scoreboard bench for rx_unit: stimulus pushes expected FIFO words, a monitor checks every read.
module tb_rx_unit;
    logic baud_clk = 1'b0;
    logic rst;

    rx_unit_if bus();

    rx_unit #(
        .FIFO_WIDTH_R(9),
        .FIFO_DEPTH_R(16)
    ) dut (
        .baud_clk(baud_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 baud_clk = ~baud_clk;

    int         n_vec  = 0;
    int         n_err  = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [8:0] sb[$];
    logic [8:0] mon_exp;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every accepted read must return the oldest expected word.
    always @(posedge baud_clk) begin
        if (!rst && bus.rd_en && !bus.empty) begin
            #1;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL rd_word: unexpected read, got %0h", {bus.parity_err, bus.data_out});
            end else begin
                mon_exp = sb.pop_front();
                if ({bus.parity_err, bus.data_out} !== mon_exp) begin
                    n_err++;
                    $display("FAIL rd_word: got %0h, expected %0h",
                             {bus.parity_err, bus.data_out}, mon_exp);
                end
            end
        end
    end

    always @(negedge baud_clk) begin
        if (bus.frame_err === 1'b1) fe_cnt++;
        if (bus.overrun === 1'b1) ov_cnt++;
    end

    // Sends one frame; parity_sel is flipped after the start bit to prove it is latched.
    task automatic send_frame(input logic [7:0] b, input logic p, input logic stop,
                              input logic psel, input logic rd_stop);
        logic [10:0] bits;
        bits = {stop, p, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus.serial_in  = bits[i];
            bus.parity_sel = (i == 0) ? psel : ~psel;
            bus.rd_en      = rd_stop && (i == 10);
            @(negedge baud_clk);
        end
        bus.rd_en     = 1'b0;
        bus.serial_in = 1'b1;
    endtask

    task automatic do_read();
        bus.rd_en = 1'b1;
        @(negedge baud_clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_data_out"}, bus.data_out, 8'h00);
        chk({tag, "_parity_err"}, 8'(bus.parity_err), 8'h0);
        chk({tag, "_empty"}, 8'(bus.empty), 8'h1);
        chk({tag, "_full"}, 8'(bus.full), 8'h0);
        chk({tag, "_rx_ready"}, 8'(bus.Rx_ready), 8'h1);
        chk({tag, "_frame_err"}, 8'(bus.frame_err), 8'h0);
        chk({tag, "_overrun"}, 8'(bus.overrun), 8'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         fe0;
        int         ov0;
        logic [7:0] b;
        logic [7:0] partial;

        bus.serial_in  = 1'b1;
        bus.parity_sel = 1'b0;
        bus.rd_en      = 1'b0;
        rst            = 1'b1;
        repeat (3) @(negedge baud_clk);
        rst = 1'b0;
        chk_reset("reset");

        // Even parity, 0xA5 with p=0 is clean.
        sb.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("a5_empty_after_stop", 8'(bus.empty), 8'h0);
        do_read();
        chk("a5_empty_after_read", 8'(bus.empty), 8'h1);

        // Odd parity 0x3C: p=0 is an error, p=1 is clean; frames back to back.
        sb.push_back({1'b1, 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        sb.push_back({1'b0, 8'h3C});
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        do_read();
        do_read();

        // Bad stop bit, then a valid frame with no idle gap.
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("frame_err_pulse", 8'(bus.frame_err), 8'h1);
        chk("frame_err_empty", 8'(bus.empty), 8'h1);
        sb.push_back({1'b0, 8'h0F});
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge baud_clk);
        chk("frame_err_once", 8'(fe_cnt - fe0), 8'h1);
        do_read();

        // Fill 0x00..0x0F and watch Rx_ready / full.
        for (int i = 0; i < 16; i++) begin
            b = 8'(i);
            sb.push_back({1'b0, b});
            send_frame(b, ^b, 1'b1, 1'b0, 1'b0);
            if (i == 13) chk("rx_ready_at_14", 8'(bus.Rx_ready), 8'h1);
            if (i == 14) begin
                chk("rx_ready_at_15", 8'(bus.Rx_ready), 8'h0);
                chk("full_at_15", 8'(bus.full), 8'h0);
            end
        end
        chk("full_at_16", 8'(bus.full), 8'h1);
        ov0 = ov_cnt;
        send_frame(8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("overrun_pulse", 8'(bus.overrun), 8'h1);
        chk("overrun_still_full", 8'(bus.full), 8'h1);
        @(negedge baud_clk);
        chk("overrun_once", 8'(ov_cnt - ov0), 8'h1);
        for (int i = 0; i < 16; i++) do_read();
        chk("drain_empty", 8'(bus.empty), 8'h1);
        do_read();
        chk("read_when_empty_holds", bus.data_out, 8'h0F);

        // Full FIFO plus a read on the stop edge accepts the frame.
        for (int i = 0; i < 16; i++) begin
            b = 8'(8'h40 + i);
            sb.push_back({~(^b), b});
            send_frame(b, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        sb.push_back({1'b0, 8'hC3});
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("rd_at_stop_full", 8'(bus.full), 8'h1);
        chk("rd_at_stop_no_overrun", 8'(bus.overrun), 8'h0);
        chk("rd_at_stop_data", bus.data_out, 8'h40);
        for (int i = 0; i < 16; i++) do_read();
        chk("drain2_empty", 8'(bus.empty), 8'h1);

        // Reset during data bit 4 with a word already buffered.
        sb.push_back({1'b0, 8'h99});
        send_frame(8'h99, 1'b0, 1'b1, 1'b0, 1'b0);
        partial = 8'h81;
        bus.serial_in = 1'b0;
        @(negedge baud_clk);
        for (int i = 0; i < 4; i++) begin
            bus.serial_in = partial[i];
            @(negedge baud_clk);
        end
        rst = 1'b1;
        bus.serial_in = partial[4];
        @(negedge baud_clk);
        rst = 1'b0;
        bus.serial_in = 1'b1;
        sb.delete();
        chk_reset("midframe_reset");
        sb.push_back({1'b0, 8'h81});
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
        do_read();
        chk("post_reset_empty", 8'(bus.empty), 8'h1);
        chk("scoreboard_drained", 8'(sb.size()), 8'h0);

        repeat (2) @(negedge baud_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rx_unit.md
Name: rx_unit

Overview:
- Receive-side counterpart of the transmit chain.
- Consumes the serial frame stream on the Tx side's serial output and deserializes each frame.
- Checks parity against the configured mode, then buffers the byte plus a parity-error flag in an internal FIFO for the external system to read.
- Drives Rx_ready back to the transmit side as the flow-control flag.

Parameters:
FIFO_WIDTH_R, 9, stored word width: 8 data bits + 1 parity-error flag
FIFO_DEPTH_R, 16, number of FIFO entries; power of two, >= 4

Ports:
baud_clk  input  1  bit-rate clock; one serial bit per cycle
rst  input  1  synchronous, active-high reset
serial_in  input  1  serial frame input; idles high
parity_sel  input  1  0 = even parity, 1 = odd parity; latched at start-bit detection
rd_en  input  1  external read request
data_out  output  8  oldest stored byte; registered
parity_err  output  1  parity-error flag of the word on data_out; registered
empty  output  1  FIFO holds 0 words
full  output  1  FIFO holds FIFO_DEPTH_R words
Rx_ready  output  1  high when count <= FIFO_DEPTH_R-2, guaranteeing room for one in-flight frame
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed frame dropped because FIFO full

Behaviour:
- Interface: one clock, baud_clk. Reset rst is synchronous and active-high.
- Frame format: start bit 0, then 8 data bits LSB first, then parity bit, then stop bit 1. One bit per baud_clk cycle.
- No oversampling. Each bit is sampled on the rising edge of its cycle.
- Reset values: data_out = 0, parity_err = 0, empty = 1, full = 0, Rx_ready = 1, frame_err = 0, overrun = 0. State = IDLE; FIFO pointers and count = 0.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: serial_in == 0 at an edge → DATA; bit_cnt = 0; latch parity_sel.
  - DATA: shift serial_in into bit[bit_cnt]. After bit_cnt == 7 → PARITY.
  - PARITY: capture received parity bit → STOP.
  - STOP: sample stop bit → IDLE, always.
    - If stop == 1: write {perr, byte} to FIFO on this same edge, unless dropped for overrun (see FIFO rules).
    - If stop == 0: discard the frame and pulse frame_err on the next cycle.
- Parity computation:
  - Even mode: perr = ^{byte, p}.
  - Odd mode: perr = ~^{byte, p}.
  - The latched parity_sel is used; a mid-frame change of parity_sel has no effect on the frame in progress.
- Timing: start sampled at edge 0, data at edges 1-8, parity at edge 9, stop at edge 10. The FIFO write occurs at edge 10, so empty deasserts after edge 10.
- Back-to-back frames: a start bit may be detected at edge 11 (the cycle right after the stop bit). No idle cycle is required.
- Read side:
  - On an edge with rd_en && !empty, data_out and parity_err load the word at the read pointer and the read pointer advances.
  - rd_en while empty is ignored; outputs hold.
- Count update:
  - Write only: +1.
  - Read only: -1.
  - Simultaneous read and write: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH_R.
- FIFO full handling:
  - A write at edge 10 while full is accepted only if a read occurs on the same edge.
  - Otherwise the word is dropped, overrun pulses next cycle, and the FIFO is unchanged.
- Status flags: empty, full and Rx_ready are derived combinationally from the registered count.
- Reset mid-frame: the partial frame is discarded, FSM returns to IDLE, and the FIFO is cleared.

Optional Feature:
- Macro: RX_ERR_CNT_EN.
- When defined, adds output err_cnt [7:0]:
  - Saturating counter that increments on each frame_err or overrun pulse.
  - Increments by 2 if both pulse in the same cycle.
  - Saturates at 255; resets to 0.
- When not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Even mode, frame byte 0xA5 with parity 0, stop 1 → empty falls after edge 10. rd_en gives data_out = 0xA5, parity_err = 0.
- Odd mode, byte 0x3C with parity 0 → stored parity_err = 1. Same byte with parity 1 → parity_err = 0.
- Frame 0x55 with stop bit 0 → frame_err pulses once, FIFO stays empty. A following valid frame 0x0F, sent with no idle gap, is stored correctly.
- 15 frames, no reads → Rx_ready falls after the 15th write. The 16th frame sets full. The 17th frame sets overrun and FIFO contents are unchanged. With rd_en asserted on the 17th frame's stop edge, the frame is accepted and count stays 16.
- Fill with 0x00..0x0F, read all 16 → bytes emerge in order; empty = 1 after the last read. A further rd_en leaves data_out = 0x0F.
- Assert rst at data bit 4 of a frame → all outputs return to reset values. The next complete frame 0x81 is received correctly.
